alu_seq: RTL and testbench

- Parametrised, registered successor to the datapath's 8-bit combinational ALU.
- Keeps the existing opcodes 0000-1010 with the same encoding.
- Adds a status flag register, a valid/ready input handshake, a one-cycle output-valid strobe, and new operations:
  - variable shift-left
  - compare (flags only)
  - rotate-right
  - multi-cycle unsigned shift-add multiply with double-width result
- Sits between the operand latch (x), the internal bus and the accumulator write-back path of the control unit.

---
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with status flags, valid/ready input handshake,
// one-cycle completion strobe and a multi-cycle shift-add unsigned multiply.
// Opcodes 0000-1010 match the legacy combinational ALU encoding.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alus,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] bus,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam logic [3:0] OP_ZERO = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_DEC  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_PASS = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_ROR  = 4'hE;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam int M  = WIDTH - 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    // Single-cycle op result bundle, computed straight from the request lines.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             err;
    } sc_res_t;

    state_t           state;
    sc_res_t          sc;
    logic [WIDTH:0]   sum, dif, inc, dec, shl;
    logic [PW-1:0]    acc, mcand, acc_nxt;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    assign in_ready = (state == S_IDLE);

    // Single-cycle datapath; CMP produces the subtract result only for flags.
    always_comb begin
        sum = {1'b0, x} + {1'b0, bus};
        dif = {1'b0, x} - {1'b0, bus};
        inc = {1'b0, x} + (WIDTH+1)'(1);
        dec = {1'b0, x} - (WIDTH+1)'(1);
        // bit WIDTH of the widened shift is the last bit pushed out (0 for amount 0)
        shl = {1'b0, x} << bus[SHW-1:0];
        sc  = '0;
        case (alus)
            OP_ZERO: sc.res = '0;
            OP_ADD: begin
                sc.res = sum[M:0];
                sc.c   = sum[WIDTH];
                sc.v   = (x[M] == bus[M]) && (sum[M] != x[M]);
            end
            OP_SUB, OP_CMP: begin
                sc.res = dif[M:0];
                sc.c   = dif[WIDTH];
                sc.v   = (x[M] != bus[M]) && (dif[M] != x[M]);
            end
            OP_AND:  sc.res = x & bus;
            OP_OR:   sc.res = x | bus;
            OP_XOR:  sc.res = x ^ bus;
            OP_INC: begin
                sc.res = inc[M:0];
                sc.c   = inc[WIDTH];
                sc.v   = !x[M] && inc[M];
            end
            OP_NOT:  sc.res = ~x;
            OP_DEC: begin
                sc.res = dec[M:0];
                sc.c   = dec[WIDTH];
                sc.v   = x[M] && !dec[M];
            end
            OP_SHR: begin
                sc.res = {1'b0, x[M:1]};
                sc.c   = x[0];
            end
            OP_PASS: sc.res = bus;
            OP_SHL: begin
                sc.res = shl[M:0];
                sc.c   = shl[WIDTH];
            end
            OP_ROR: begin
                sc.res = {x[0], x[M:1]};
                sc.c   = x[0];
            end
            default: sc.err = 1'b1;  // 1111 (1100 never completes here)
        endcase
    end

    // One shift-add multiply step: add the shifted multiplicand when the
    // current multiplier lsb is set.
    always_comb begin
        acc_nxt = mplier[0] ? acc + mcand : acc;
    end

    // Control FSM, result/flag registers and multiply iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            dout      <= '0;
            dout_hi   <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (alus == OP_MUL) begin
                            state  <= S_MUL;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, x};
                            mplier <= bus;
                            cnt    <= CW'(WIDTH);
                        end else begin
                            out_valid <= 1'b1;
                            flag_z    <= (sc.res == '0);
                            flag_n    <= sc.res[M];
                            flag_c    <= sc.c;
                            flag_v    <= sc.v;
                            err       <= sc.err;
                            if (alus != OP_CMP) begin
                                dout    <= sc.res;
                                dout_hi <= '0;
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b1;
                        dout      <= acc_nxt[M:0];
                        dout_hi   <= acc_nxt[PW-1:WIDTH];
                        flag_z    <= (acc_nxt == '0);
                        flag_n    <= acc_nxt[PW-1];
                        flag_c    <= |acc_nxt[PW-1:WIDTH];
                        flag_v    <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scenarios plus randomized ops, checked against an
// arithmetic reference model of the ALU's opcode rules.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alus;
    logic [7:0] x, bus;
    logic       in_valid;
    logic       in_ready, out_valid;
    logic [7:0] dout, dout_hi;
    logic       flag_z, flag_n, flag_c, flag_v, err;

    int checks = 0;
    int errors = 0;

    // expected architectural state
    logic [7:0] m_dout, m_hi;
    logic       m_z, m_n, m_c, m_v, m_err;

    alu_seq #(.WIDTH(8), .SHW(3)) dut (
        .clk(clk), .rst_n(rst_n), .alus(alus), .x(x), .bus(bus),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .dout(dout), .dout_hi(dout_hi), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: compute result/flags from the opcode rules with integer math.
    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, s, p;
        logic [31:0] rv;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        r = 0; m_c = 0; m_v = 0; m_err = 0;
        case (op)
            4'h0: r = 0;
            4'h1: begin r = ua + ub; m_c = (r > 255); m_v = (sa + sb > 127) || (sa + sb < -128); end
            4'h2, 4'hD: begin r = ua - ub; m_c = (ua < ub); m_v = (sa - sb > 127) || (sa - sb < -128); end
            4'h3: r = ua & ub;
            4'h4: r = ua | ub;
            4'h5: r = ua ^ ub;
            4'h6: begin r = ua + 1; m_c = (r > 255); m_v = (sa + 1 > 127); end
            4'h7: r = 255 - ua;
            4'h8: begin r = ua - 1; m_c = (ua < 1); m_v = (sa - 1 < -128); end
            4'h9: begin r = ua / 2; m_c = ua[0]; end
            4'hA: r = ub;
            4'hB: begin s = ub % 8; r = ua * (1 << s); m_c = (s > 0) ? ((ua >> (8 - s)) & 1) : 0; end
            4'hE: begin r = (ua / 2) + (ua % 2) * 128; m_c = ua[0]; end
            4'hF: begin r = 0; m_err = 1; end
            default: r = 0;
        endcase
        if (op == 4'hC) begin
            p = ua * ub;
            rv = p;
            m_dout = rv[7:0];
            m_hi   = rv[15:8];
            m_z = (p == 0); m_n = rv[15]; m_c = (p > 255); m_v = 0;
        end else begin
            rv = r;
            if (op != 4'hD) begin
                m_dout = rv[7:0];
                m_hi   = 8'h00;
            end
            m_z = (rv[7:0] == 0);
            m_n = rv[7];
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] op);
        chk({tag, ".dout"}, dout, m_dout);
        chk({tag, ".hi"}, dout_hi, m_hi);
        chk({tag, ".z"}, flag_z, m_z);
        if (op != 4'hC) chk({tag, ".n"}, flag_n, m_n);
        chk({tag, ".c"}, flag_c, m_c);
        chk({tag, ".v"}, flag_v, m_v);
        chk({tag, ".err"}, err, m_err);
    endtask

    // Issue one request, wait for completion, compare, confirm a single strobe.
    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        alus = op; x = a; bus = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 8'($urandom); bus = 8'($urandom); alus = 4'($urandom);
        model(op, a, b);
        if (op == 4'hC) begin
            n = 0;
            chk({tag, ".busy"}, in_ready, 1'b0);
            while (!out_valid && n < 20) begin
                if (n == 2) begin
                    in_valid = 1'b1; alus = 4'h1; x = 8'h00; bus = 8'h00;
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                n++;
                if (!out_valid) chk({tag, ".busy"}, in_ready, 1'b0);
            end
            chk({tag, ".lat"}, n, 8);
        end
        chk({tag, ".ov"}, out_valid, 1'b1);
        chk({tag, ".rdy"}, in_ready, 1'b1);
        check_outs(tag, op);
        @(posedge clk); #1;
        chk({tag, ".strobe"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [3:0] op;
        rst_n = 1'b0; in_valid = 1'b0; alus = 4'h0; x = 8'h00; bus = 8'h00;
        m_dout = 0; m_hi = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst.ov", out_valid, 1'b0);
        chk("rst.rdy", in_ready, 1'b1);
        check_outs("rst", 4'h0);

        // directed scenarios
        run("add", 4'h1, 8'hF0, 8'h20);
        chk("add.lit", {dout, flag_c, flag_z, flag_v, flag_n}, {8'h10, 4'b1000});
        run("sub", 4'h2, 8'h80, 8'h01);
        chk("sub.lit", {dout, flag_v, flag_c}, {8'h7F, 2'b10});
        run("cmp", 4'hD, 8'h05, 8'h09);
        chk("cmp.lit", {dout, flag_c, flag_n, flag_z}, {8'h7F, 3'b110});

        // back-to-back: in_valid held across two accepts
        @(negedge clk);
        alus = 4'h3; x = 8'hF0; bus = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1;
        alus = 4'h5; x = 8'hFF; bus = 8'hFF;
        model(4'h3, 8'hF0, 8'h3C);
        chk("b2b1.ov", out_valid, 1'b1);
        check_outs("b2b1", 4'h3);
        chk("b2b1.lit", dout, 8'h30);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(4'h5, 8'hFF, 8'hFF);
        chk("b2b2.ov", out_valid, 1'b1);
        check_outs("b2b2", 4'h5);
        chk("b2b2.z", flag_z, 1'b1);
        @(posedge clk); #1;
        chk("b2b.strobe", out_valid, 1'b0);

        run("mul", 4'hC, 8'hFF, 8'hFF);
        chk("mul.lit", {dout_hi, dout, flag_c}, {16'hFE01, 1'b1});
        run("shl", 4'hB, 8'h81, 8'h01);
        chk("shl.lit", {dout, flag_c}, {8'h02, 1'b1});
        run("shl0", 4'hB, 8'h81, 8'h00);
        run("ror", 4'hE, 8'h01, 8'h00);
        chk("ror.lit", {dout, flag_c, flag_n}, {8'h80, 2'b11});
        run("ill", 4'hF, 8'h12, 8'h34);
        chk("ill.lit", {dout, err, flag_z}, {8'h00, 2'b11});
        run("inc", 4'h6, 8'h7F, 8'h00);
        run("dec", 4'h8, 8'h00, 8'h00);
        run("mul0", 4'hC, 8'h00, 8'h37);

        // reset on the 4th multiply cycle aborts it
        @(negedge clk);
        alus = 4'hC; x = 8'h0F; bus = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rmul.ov", out_valid, 1'b0);
        chk("rmul.dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rmul.rdy", in_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rmul.noov", out_valid, 1'b0);
        end
        m_dout = 0; m_hi = 0;
        run("radd", 4'h1, 8'h11, 8'h22);

        // randomized ops
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            run("rnd", op, 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
